rc5_key_schedule: RTL

- RC5-16 key-expansion stage: turns the 128-bit user key and round count into the expanded subkey table S[0..t-1], with t = 2*(r+1) 16-bit words.
- Sits directly upstream of the RC5 encrypt/decrypt datapath (algo), which reads S through a synchronous read port once ready is high.
- Runs one mixing iteration per clock; the table is held in a register array internal to this block.

---
 rtl/rc5_pkg.sv | 29 ++
 rtl/rc5_rotl16.sv | 12 +
 rtl/rc5_key_schedule.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/rc5_pkg.sv
// Shared types and constants for the RC5-16 key schedule and the algo datapath.
// Provides the word type, the magic constants, the FSM encoding and the table sizing helpers.
package rc5_pkg;

  localparam int W          = 16;
  localparam int C_WORDS    = 8;
  localparam int MAX_ROUNDS = 31;
  localparam int MAX_T      = 2 * (MAX_ROUNDS + 1);

  typedef logic [W-1:0] word_t;

  localparam word_t P16 = 16'hB7E1;
  localparam word_t Q16 = 16'h9E37;

  typedef enum logic [1:0] {IDLE, INIT, MIX, DONE} state_t;

  // t = 2*r + 2, always in 2..64
  function automatic logic [6:0] table_words(input logic [4:0] rounds);
    return {1'b0, rounds, 1'b0} + 7'd2;
  endfunction

  // Index of the final mixing iteration: 3*max(t, 8) - 1, always in 23..191
  function automatic logic [7:0] mix_last_iter(input logic [6:0] t);
    logic [7:0] m;
    m = (t < 7'd8) ? 8'd8 : {1'b0, t};
    return (m << 1) + m - 8'd1;
  endfunction

endpackage

// File: rtl/rc5_rotl16.sv
// Combinational 16-bit left rotate by a 4-bit amount.
// Shared between the key schedule and the encrypt/decrypt datapath.
module rc5_rotl16 (
  input  logic [15:0] din,
  input  logic [3:0]  amt,
  output logic [15:0] dout
);

  // A right shift by 16 (amt = 0) yields zero, so the OR leaves din untouched.
  assign dout = (din << amt) | (din >> (5'd16 - {1'b0, amt}));

endmodule

// File: rtl/rc5_key_schedule.sv
// RC5-16 key expansion: fills S[0..t-1] one word per cycle, then runs 3*max(t,8) mixing
// iterations, one per cycle, and exposes the table through a registered read port.
module rc5_key_schedule
  import rc5_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [4:0]   num_rounds,
  input  logic [127:0] key,
  output logic         busy,
  output logic         done,
  output logic         ready,
  output logic [6:0]   t_words,
  input  logic [5:0]   s_raddr,
  output logic [15:0]  s_rdata
);

  state_t     state;
  logic [5:0] idx_i;
  logic [2:0] idx_j;
  logic [7:0] iter;
  logic [7:0] last_iter;
  word_t      reg_a;
  word_t      reg_b;
  word_t      init_val;

  word_t      s_mem [MAX_T];
  word_t      l_mem [C_WORDS];

  word_t      a_sum;
  word_t      a_new;
  word_t      b_sum;
  word_t      b_new;
  logic [3:0] b_amt;
  logic       i_last;
  logic       start_ok;

  assign start_ok = (state == IDLE) && start;
  assign i_last   = ({1'b0, idx_i} == (t_words - 7'd1));

  // One mixing iteration: A' feeds both the S write-back and the B rotate amount.
  assign a_sum = s_mem[idx_i] + reg_a + reg_b;
  assign b_sum = l_mem[idx_j] + a_new + reg_b;
  // Only the low nibble of A'+B sets the rotate, and it depends only on the low nibbles.
  assign b_amt = a_new[3:0] + reg_b[3:0];

  rc5_rotl16 u_rotl_a (
    .din  (a_sum),
    .amt  (4'd3),
    .dout (a_new)
  );

  rc5_rotl16 u_rotl_b (
    .din  (b_sum),
    .amt  (b_amt),
    .dout (b_new)
  );

  // NOTE: the S and L arrays have no reset; every word is written before it is read, and
  // leaving them out of the reset keeps them plain register-file storage.
  always_ff @(posedge clk) begin
    if (start_ok) begin
      for (int k = 0; k < C_WORDS; k++) begin
        l_mem[k] <= key[16*k +: 16];
      end
    end
    if (state == INIT) begin
      s_mem[idx_i] <= init_val;
    end else if (state == MIX) begin
      s_mem[idx_i] <= a_new;
      l_mem[idx_j] <= b_new;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      ready     <= 1'b0;
      t_words   <= '0;
      s_rdata   <= '0;
      idx_i     <= '0;
      idx_j     <= '0;
      iter      <= '0;
      last_iter <= '0;
      reg_a     <= '0;
      reg_b     <= '0;
      init_val  <= '0;
    end else begin
      done <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            t_words   <= table_words(num_rounds);
            last_iter <= mix_last_iter(table_words(num_rounds));
            idx_i     <= '0;
            init_val  <= P16;
            ready     <= 1'b0;
            busy      <= 1'b1;
            state     <= INIT;
          end
        end

        INIT: begin
          // init_val tracks P16 + i*Q16 without a multiplier
          init_val <= init_val + Q16;
          if (i_last) begin
            idx_i <= '0;
            idx_j <= '0;
            reg_a <= '0;
            reg_b <= '0;
            iter  <= '0;
            state <= MIX;
          end else begin
            idx_i <= idx_i + 6'd1;
          end
        end

        MIX: begin
          reg_a <= a_new;
          reg_b <= b_new;
          idx_i <= i_last ? 6'd0 : idx_i + 6'd1;
          idx_j <= idx_j + 3'd1;
          iter  <= iter + 8'd1;
          if (iter == last_iter) begin
            state <= DONE;
          end
        end

        DONE: begin
          done  <= 1'b1;
          ready <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase

      // The read port stays quiet unless a finished table is on offer.
      if (ready && !busy) begin
        s_rdata <= s_mem[s_raddr];
      end else begin
        s_rdata <= '0;
      end
    end
  end

endmodule
